// File: rtl/gic_pkg.sv
// rtl/gic_pkg.sv - GIC slave command/status codes and frame state encoding
package gic_pkg;

  localparam logic [3:0] CMD_RD = 4'h1;
  localparam logic [3:0] CMD_WR = 4'h2;

  localparam logic [3:0] ST_ACK = 4'hA;
  localparam logic [3:0] ST_NAK = 4'hE;
  localparam logic [3:0] ST_TMO = 4'hF;

  localparam logic [3:0] ADDR_LAST = 4'd3;
  localparam logic [3:0] DATA_LAST = 4'd7;
  localparam logic [3:0] DATA_NIBS = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP,
    S_DONE
  } gic_state_e;

endpackage

// File: rtl/gic_nibble_shreg.sv
// rtl/gic_nibble_shreg.sv - 32-bit nibble shift register with parallel load
module gic_nibble_shreg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift,
  input  logic [3:0]  nib_in,
  output logic [31:0] data,
  output logic [3:0]  nib_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {data[27:0], nib_in};
    end
  end

  // MSB nibble leaves first, so one register serves both shift-in and shift-out
  assign nib_out = data[31:28];

endmodule

// File: rtl/gic_slave.sv
// rtl/gic_slave.sv - GIC nibble-serial slave bridging frames onto a local bus
module gic_slave
  import gic_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        gic_cs_i,
  input  logic [3:0]  gic_dat_i,
  output logic [3:0]  gic_dat_o,
  output logic [15:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic        bus_we_o,
  output logic        bus_stb_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i
);

  gic_state_e  state;
  logic [3:0]  nib_cnt;
  logic [7:0]  tmo_cnt;
  logic        is_wr;
  logic        rd_ok;
  logic        cs_lost;

  logic        sh_load;
  logic        sh_shift;
  logic [3:0]  sh_nib_in;
  logic [31:0] sh_data;
  logic [3:0]  sh_nib_out;
  logic        bus_done;
  logic        rsp_data;

  assign bus_done = bus_ack_i || (tmo_cnt == (TIMEOUT - 8'd1));
  assign rsp_data = rd_ok && (nib_cnt < DATA_NIBS);

  always_comb begin
    sh_load   = (state == S_BUS) && bus_ack_i;
    sh_shift  = 1'b0;
    sh_nib_in = gic_dat_i;
    if ((state == S_ADDR || state == S_WDATA) && gic_cs_i) begin
      sh_shift = 1'b1;
    end else if (state == S_RESP && gic_cs_i && rsp_data) begin
      sh_shift  = 1'b1;
      sh_nib_in = 4'h0;
    end
  end

  gic_nibble_shreg u_shreg (
    .clk       (sys_clk_i),
    .rst       (sys_rst_i),
    .load      (sh_load),
    .load_data (bus_dat_i),
    .shift     (sh_shift),
    .nib_in    (sh_nib_in),
    .data      (sh_data),
    .nib_out   (sh_nib_out)
  );

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state     <= S_IDLE;
      nib_cnt   <= '0;
      tmo_cnt   <= '0;
      is_wr     <= 1'b0;
      rd_ok     <= 1'b0;
      cs_lost   <= 1'b0;
      gic_dat_o <= 4'h0;
      bus_adr_o <= '0;
      bus_dat_o <= '0;
      bus_we_o  <= 1'b0;
      bus_stb_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          gic_dat_o <= 4'h0;
          nib_cnt   <= '0;
          tmo_cnt   <= '0;
          rd_ok     <= 1'b0;
          cs_lost   <= 1'b0;
          if (gic_cs_i) begin
            if (gic_dat_i == CMD_RD || gic_dat_i == CMD_WR) begin
              is_wr <= (gic_dat_i == CMD_WR);
              state <= S_ADDR;
            end else begin
              gic_dat_o <= ST_NAK;
              state     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (!gic_cs_i) begin
            state <= S_IDLE;
          end else if (nib_cnt == ADDR_LAST) begin
            nib_cnt   <= '0;
            bus_adr_o <= {sh_data[11:0], gic_dat_i};
            if (is_wr) begin
              state <= S_WDATA;
            end else begin
              bus_we_o  <= 1'b0;
              bus_stb_o <= 1'b1;
              state     <= S_BUS;
            end
          end else begin
            nib_cnt <= nib_cnt + 4'd1;
          end
        end

        S_WDATA: begin
          if (!gic_cs_i) begin
            state <= S_IDLE;
          end else if (nib_cnt == DATA_LAST) begin
            nib_cnt   <= '0;
            bus_dat_o <= {sh_data[27:0], gic_dat_i};
            bus_we_o  <= 1'b1;
            bus_stb_o <= 1'b1;
            state     <= S_BUS;
          end else begin
            nib_cnt <= nib_cnt + 4'd1;
          end
        end

        S_BUS: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (!gic_cs_i) cs_lost <= 1'b1;
          if (bus_done) begin
            bus_stb_o <= 1'b0;
            bus_we_o  <= 1'b0;
            tmo_cnt   <= '0;
            nib_cnt   <= '0;
            // An abandoned frame still completes the bus access but stays silent
            if (cs_lost || !gic_cs_i) begin
              state <= S_IDLE;
            end else begin
              gic_dat_o <= bus_ack_i ? ST_ACK : ST_TMO;
              rd_ok     <= bus_ack_i && !is_wr;
              state     <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (!gic_cs_i) begin
            gic_dat_o <= 4'h0;
            state     <= S_IDLE;
          end else if (rsp_data) begin
            gic_dat_o <= sh_nib_out;
            nib_cnt   <= nib_cnt + 4'd1;
          end else begin
            gic_dat_o <= 4'h0;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          gic_dat_o <= 4'h0;
          if (!gic_cs_i) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gic_slave.sv
// tb/tb_gic_slave.sv - directed self-checking bench for gic_slave
module tb_gic_slave;
  import gic_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic [3:0]  din = 4'h0;
  logic [31:0] bdin = '0;
  logic        ack = 1'b0;
  logic [3:0]  dout;
  logic [15:0] adr;
  logic [31:0] bdo;
  logic        we;
  logic        stb;

  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] expv;

  gic_slave #(.TIMEOUT(8'd16)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .gic_cs_i  (cs),
    .gic_dat_i (din),
    .gic_dat_o (dout),
    .bus_adr_o (adr),
    .bus_dat_o (bdo),
    .bus_we_o  (we),
    .bus_stb_o (stb),
    .bus_dat_i (bdin),
    .bus_ack_i (ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] v);
    din = v;
    step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset values
    rst = 1'b1;
    step();
    step();
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_bdo", bdo, 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    rst = 1'b0;
    step();

    // read 0x0010, acked 3 cycles after strobe
    cs = 1'b1;
    nib(4'h1); nib(4'h0); nib(4'h0); nib(4'h1); nib(4'h0);
    check("rd_stb", 32'(stb), 32'd1);
    check("rd_adr", 32'(adr), 32'h0010);
    check("rd_we", 32'(we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_dout", 32'(dout), 32'd0);
      step();
    end
    check("rd_stb_held", 32'(stb), 32'd1);
    ack = 1'b1;
    bdin = 32'hDEADBEEF;
    step();
    ack = 1'b0;
    check("rd_status", 32'(dout), 32'hA);
    check("rd_stb_fall", 32'(stb), 32'd0);
    expv = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rd_data_nib", 32'(dout), 32'(expv[31:28]));
      expv = {expv[27:0], 4'h0};
    end
    step();
    check("rd_done_dout", 32'(dout), 32'd0);
    cs = 1'b0;
    step();
    check("rd_idle", 32'(dut.state), 32'(S_IDLE));

    // write 0x1234 <= 0x0000CAFE, acked immediately
    cs = 1'b1;
    nib(4'h2); nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    check("wr_no_stb_in_wdata", 32'(stb), 32'd0);
    nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h0);
    nib(4'hC); nib(4'hA); nib(4'hF); nib(4'hE);
    check("wr_stb", 32'(stb), 32'd1);
    check("wr_we", 32'(we), 32'd1);
    check("wr_adr", 32'(adr), 32'h1234);
    check("wr_bdo", bdo, 32'h0000CAFE);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("wr_status", 32'(dout), 32'hA);
    check("wr_stb_fall", 32'(stb), 32'd0);
    step();
    check("wr_no_data", 32'(dout), 32'd0);
    cs = 1'b0;
    step();

    // illegal command
    cs = 1'b1;
    nib(4'h7);
    check("ill_status", 32'(dout), 32'hE);
    check("ill_stb", 32'(stb), 32'd0);
    step();
    check("ill_no_data", 32'(dout), 32'd0);
    step();
    check("ill_stb_later", 32'(stb), 32'd0);
    cs = 1'b0;
    step();
    check("ill_idle", 32'(dut.state), 32'(S_IDLE));

    // timeout with TIMEOUT=16
    cs = 1'b1;
    nib(4'h1); nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h0);
    n = 0;
    while (stb === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("tmo_stb_cycles", 32'(n), 32'd16);
    check("tmo_status", 32'(dout), 32'hF);
    step();
    check("tmo_no_data", 32'(dout), 32'd0);
    cs = 1'b0;
    step();

    // abort after 2 address nibbles, with a stray ack
    cs = 1'b1;
    nib(4'h1); nib(4'hA); nib(4'hB);
    ack = 1'b1;
    cs = 1'b0;
    step();
    ack = 1'b0;
    check("abt_idle", 32'(dut.state), 32'(S_IDLE));
    check("abt_stb", 32'(stb), 32'd0);
    check("abt_dout", 32'(dout), 32'd0);
    step();
    check("abt_stb_later", 32'(stb), 32'd0);

    // next frame decodes correctly
    cs = 1'b1;
    nib(4'h1); nib(4'h5); nib(4'hA); nib(4'h5); nib(4'hA);
    check("nxt_adr", 32'(adr), 32'h5A5A);
    check("nxt_stb", 32'(stb), 32'd1);
    ack = 1'b1;
    bdin = 32'h12345678;
    step();
    ack = 1'b0;
    check("nxt_status", 32'(dout), 32'hA);
    expv = 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      step();
      check("nxt_data_nib", 32'(dout), 32'(expv[31:28]));
      expv = {expv[27:0], 4'h0};
    end
    step();
    check("nxt_done_dout", 32'(dout), 32'd0);
    cs = 1'b0;
    step();

    // cs falls during BUS: access completes silently
    cs = 1'b1;
    nib(4'h1); nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h3);
    check("bcs_stb", 32'(stb), 32'd1);
    cs = 1'b0;
    step();
    check("bcs_stb_held", 32'(stb), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("bcs_stb_fall", 32'(stb), 32'd0);
    check("bcs_no_resp", 32'(dout), 32'd0);
    check("bcs_idle", 32'(dut.state), 32'(S_IDLE));

    // reset during an active access
    cs = 1'b1;
    nib(4'h1); nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h4);
    check("rma_stb", 32'(stb), 32'd1);
    rst = 1'b1;
    step();
    check("rma_stb_drop", 32'(stb), 32'd0);
    check("rma_dout", 32'(dout), 32'd0);
    check("rma_idle", 32'(dut.state), 32'(S_IDLE));
    rst = 1'b0;
    cs = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
